// File: rtl/bip_datapath_pkg.sv
// Shared BIP1 control encodings and default widths for the datapath and the decoder.
package bip_datapath_pkg;

    localparam int DEF_NB_DATA    = 16;
    localparam int DEF_NB_OPERAND = 11;
    localparam int DEF_NB_ADDR    = 11;

    typedef enum logic [1:0] {
        SELA_RAM  = 2'b00,
        SELA_IMM  = 2'b01,
        SELA_ALU  = 2'b10,
        SELA_HOLD = 2'b11
    } sela_e;

    typedef enum logic {
        SELB_RAM = 1'b0,
        SELB_IMM = 1'b1
    } selb_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

endpackage

// File: rtl/data_memory.sv
// BIP1 data RAM: synchronous write, asynchronous read; writes are blocked while reset is asserted.
module data_memory #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    output logic [NB_DATA-1:0] o_rd_data
);

    logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

    // No reset on the array itself: reset only suppresses a write in progress.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && i_rst) begin
            mem_q[i_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_addr];

endmodule

// File: rtl/bip_datapath.sv
// BIP1 datapath: accumulator, add/sub ALU with flags, operand sign-extender and data RAM.
module bip_datapath
    import bip_datapath_pkg::*;
#(
    parameter int NB_DATA    = DEF_NB_DATA,
    parameter int NB_OPERAND = DEF_NB_OPERAND,
    parameter int NB_ADDR    = DEF_NB_ADDR
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_OPERAND-1:0] i_operand,
    input  logic [1:0]            i_SelA,
    input  logic                  i_SelB,
    input  logic                  i_WrAcc,
    input  logic                  i_op,
    input  logic                  i_WrRam,
    input  logic                  i_RdRam,
    output logic [NB_DATA-1:0]    o_acc,
    output logic                  o_zero,
    output logic                  o_carry,
    output logic                  o_ovf
);

    logic [NB_DATA-1:0] acc_q, acc_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic [NB_DATA-1:0] imm;
    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] mem_rd_data;
    logic [NB_DATA-1:0] rd_data;
    logic [NB_DATA-1:0] b_val;
    logic [NB_DATA-1:0] b_eff;
    logic [NB_DATA:0]   alu_sum;
    logic [NB_DATA-1:0] alu_res;
    logic               alu_carry;
    logic               alu_ovf;

    assign imm     = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
    assign addr    = i_operand[NB_ADDR-1:0];
    assign rd_data = i_RdRam ? mem_rd_data : '0;
    assign b_val   = (i_SelB == SELB_IMM) ? imm : rd_data;

    // Subtraction adds the two's complement of B; no-borrow is taken from an unsigned compare
    // because acc + (~B+1) loses the carry when B is zero.
    assign b_eff     = (i_op == OP_SUB) ? (~b_val + {{(NB_DATA-1){1'b0}}, 1'b1}) : b_val;
    assign alu_sum   = {1'b0, acc_q} + {1'b0, b_eff};
    assign alu_res   = alu_sum[NB_DATA-1:0];
    assign alu_carry = (i_op == OP_SUB) ? (acc_q >= b_val) : alu_sum[NB_DATA];
    assign alu_ovf   = (acc_q[NB_DATA-1] == b_eff[NB_DATA-1]) &&
                       (alu_res[NB_DATA-1] != acc_q[NB_DATA-1]);

    always_comb begin
        acc_d   = acc_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (i_WrAcc) begin
            case (sela_e'(i_SelA))
                SELA_RAM:  acc_d = rd_data;
                SELA_IMM:  acc_d = imm;
                SELA_ALU: begin
                    acc_d   = alu_res;
                    zero_d  = (alu_res == '0);
                    carry_d = alu_carry;
                    ovf_d   = alu_ovf;
                end
                default:   acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            acc_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // The RAM stores the accumulator as it was before this edge.
    data_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_data_memory (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_WrRam),
        .i_addr    (addr),
        .i_wr_data (acc_q),
        .o_rd_data (mem_rd_data)
    );

    assign o_acc   = acc_q;
    assign o_zero  = zero_q;
    assign o_carry = carry_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_bip_datapath.sv
// Bench for bip_datapath: literal vector table, hand sequences for multi-cycle cases, random vs. model.
module tb_bip_datapath;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [10:0] i_operand = '0;
    logic [1:0]  i_SelA = '0;
    logic        i_SelB = 1'b0;
    logic        i_WrAcc = 1'b0;
    logic        i_op = 1'b0;
    logic        i_WrRam = 1'b0;
    logic        i_RdRam = 1'b0;
    logic [15:0] o_acc;
    logic        o_zero, o_carry, o_ovf;

    int total = 0;
    int bad   = 0;

    bip_datapath dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_operand (i_operand),
        .i_SelA    (i_SelA),
        .i_SelB    (i_SelB),
        .i_WrAcc   (i_WrAcc),
        .i_op      (i_op),
        .i_WrRam   (i_WrRam),
        .i_RdRam   (i_RdRam),
        .o_acc     (o_acc),
        .o_zero    (o_zero),
        .o_carry   (o_carry),
        .o_ovf     (o_ovf)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    // reference model state
    logic [15:0] m_acc = '0;
    logic        m_z = 1'b1, m_c = 1'b0, m_o = 1'b0;
    logic [15:0] m_mem [2048];

    logic [18:0] exp_q [$];

    typedef struct {
        logic        rst;
        logic [10:0] operand;
        logic [1:0]  sela;
        logic        selb, wracc, op, wrram, rdram;
        logic [15:0] e_acc;
        logic        e_z, e_c, e_o;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic rst, input logic [10:0] operand, input logic [1:0] sela,
                                input logic selb, input logic wracc, input logic op,
                                input logic wrram, input logic rdram, input logic [15:0] e_acc,
                                input logic e_z, input logic e_c, input logic e_o);
        vec_t v;
        v.rst = rst; v.operand = operand; v.sela = sela; v.selb = selb; v.wracc = wracc;
        v.op = op; v.wrram = wrram; v.rdram = rdram;
        v.e_acc = e_acc; v.e_z = e_z; v.e_c = e_c; v.e_o = e_o;
        return v;
    endfunction

    function automatic int sgn16(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    // Behaviour of one clock edge, from the instruction rules in plain arithmetic.
    task automatic model_step(input logic rst, input logic [10:0] operand, input logic [1:0] sela,
                              input logic selb, input logic wracc, input logic op,
                              input logic wrram, input logic rdram);
        int unsigned a, b, bp, res;
        int          sr, opv;
        logic [15:0] rd, imm;
        if (!rst) begin
            m_acc = '0; m_z = 1'b1; m_c = 1'b0; m_o = 1'b0;
            return;
        end
        rd  = rdram ? m_mem[operand] : 16'h0000;
        opv = (int'(operand) >= 1024) ? int'(operand) - 2048 : int'(operand);
        imm = 16'(opv);
        b   = selb ? int'(imm) : int'(rd);
        a   = int'(m_acc);
        if (wrram) m_mem[operand] = m_acc;
        if (wracc) begin
            case (sela)
                2'd0: m_acc = rd;
                2'd1: m_acc = imm;
                2'd2: begin
                    bp  = op ? ((65536 - b) % 65536) : b;
                    res = op ? ((a + 65536 - b) % 65536) : ((a + b) % 65536);
                    m_c = op ? (a >= b) : ((a + b) > 65535);
                    sr  = sgn16(a) + sgn16(bp);
                    m_o = (sr > 32767) || (sr < -32768);
                    m_z = (res == 0);
                    m_acc = 16'(res);
                end
                default: ;
            endcase
        end
    endtask

    // driver
    task automatic apply(input logic rst, input logic [10:0] operand, input logic [1:0] sela,
                         input logic selb, input logic wracc, input logic op,
                         input logic wrram, input logic rdram);
        i_rst = rst; i_operand = operand; i_SelA = sela; i_SelB = selb;
        i_WrAcc = wracc; i_op = op; i_WrRam = wrram; i_RdRam = rdram;
        @(posedge i_clk);
        model_step(rst, operand, sela, selb, wracc, op, wrram, rdram);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [15:0] acc, input logic z,
                               input logic c, input logic o);
        check({name, ".acc"}, 32'(o_acc), 32'(acc));
        check({name, ".flags"}, {29'd0, o_zero, o_carry, o_ovf}, {29'd0, z, c, o});
    endtask

    task automatic do_reset();
        apply(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic ldi(input logic [10:0] v);
        apply(1'b1, v, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic alui(input logic op, input logic [10:0] v);
        apply(1'b1, v, 2'b10, 1'b1, 1'b1, op, 1'b0, 1'b0);
    endtask
    task automatic sto(input logic [10:0] a);
        apply(1'b1, a, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
    task automatic ld(input logic [10:0] a);
        apply(1'b1, a, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask
    // acc <= 2*acc through a scratch word
    task automatic dbl(input logic [10:0] a);
        sto(a);
        apply(1'b1, a, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [18:0] exp_v;
        logic        r_rst, r_selb, r_wracc, r_op, r_wrram, r_rdram;
        logic [1:0]  r_sela;
        logic [10:0] r_operand;

        for (int i = 0; i < 2048; i++) m_mem[i] = 16'h0000;

        // vector table: starts from reset state
        tbl.push_back(mk(1, 11'h7FF, 2'b01, 1, 1, 0, 0, 0, 16'hFFFF, 1, 0, 0)); // LDI -1
        tbl.push_back(mk(1, 11'h001, 2'b10, 1, 1, 0, 0, 0, 16'h0000, 1, 1, 0)); // ADDI 1
        tbl.push_back(mk(1, 11'h0A5, 2'b01, 1, 1, 0, 0, 0, 16'h00A5, 1, 1, 0)); // LDI A5
        tbl.push_back(mk(1, 11'h010, 2'b00, 0, 0, 0, 1, 0, 16'h00A5, 1, 1, 0)); // STO 10
        tbl.push_back(mk(1, 11'h010, 2'b00, 0, 1, 0, 0, 1, 16'h00A5, 1, 1, 0)); // LD 10
        tbl.push_back(mk(1, 11'h003, 2'b01, 1, 1, 0, 1, 0, 16'h0003, 1, 1, 0)); // STO+LDI 3
        tbl.push_back(mk(1, 11'h003, 2'b00, 0, 1, 0, 0, 1, 16'h00A5, 1, 1, 0)); // LD 3 -> old acc
        tbl.push_back(mk(1, 11'h003, 2'b10, 0, 1, 0, 0, 1, 16'h014A, 0, 0, 0)); // ADD 3
        tbl.push_back(mk(1, 11'h005, 2'b11, 1, 1, 0, 0, 0, 16'h014A, 0, 0, 0)); // SelA hold
        tbl.push_back(mk(1, 11'h005, 2'b10, 1, 0, 0, 0, 0, 16'h014A, 0, 0, 0)); // WrAcc=0
        tbl.push_back(mk(1, 11'h003, 2'b00, 0, 1, 0, 0, 1, 16'h00A5, 0, 0, 0)); // LD keeps flags
        tbl.push_back(mk(1, 11'h003, 2'b10, 0, 1, 1, 0, 1, 16'h0000, 1, 1, 0)); // SUB 3
        tbl.push_back(mk(1, 11'h003, 2'b00, 0, 1, 0, 0, 0, 16'h0000, 1, 1, 0)); // LD, RdRam=0
        tbl.push_back(mk(1, 11'h001, 2'b10, 1, 1, 1, 0, 0, 16'hFFFF, 0, 0, 0)); // SUBI 1 borrow
        tbl.push_back(mk(1, 11'h003, 2'b10, 0, 1, 0, 1, 1, 16'h00A4, 0, 1, 0)); // ADD+STO same addr
        tbl.push_back(mk(1, 11'h003, 2'b00, 0, 1, 0, 0, 1, 16'hFFFF, 0, 1, 0)); // LD sees new word
        tbl.push_back(mk(1, 11'h000, 2'b00, 0, 0, 0, 0, 0, 16'hFFFF, 0, 1, 0)); // NOP

        // reset with random strobes; preloaded word survives
        do_reset();
        ldi(11'h246);
        dbl(11'd6); dbl(11'd6); dbl(11'd6);
        alui(1'b0, 11'h004);
        check_state("preload", 16'h1234, 1'b0, 1'b0, 1'b0);
        sto(11'd5);
        for (int i = 0; i < 2; i++)
            apply(1'b0, 11'($urandom_range(0, 2047)), 2'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        check_state("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
        ld(11'd5);
        check("reset_ram_kept", 32'(o_acc), 32'h1234);

        // table
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].operand, tbl[i].sela, tbl[i].selb, tbl[i].wracc,
                  tbl[i].op, tbl[i].wrram, tbl[i].rdram);
            check_state($sformatf("tbl[%0d]", i), tbl[i].e_acc, tbl[i].e_z, tbl[i].e_c, tbl[i].e_o);
        end

        // signed overflow both directions
        ldi(11'h400);
        for (int i = 0; i < 5; i++) dbl(11'd6);
        check("ovf_setup", 32'(o_acc), 32'h8000);
        alui(1'b1, 11'h001);
        check_state("subi_ovf", 16'h7FFF, 1'b0, 1'b1, 1'b1);
        alui(1'b0, 11'h001);
        check_state("addi_ovf", 16'h8000, 1'b0, 1'b0, 1'b1);

        // reset during a store: store suppressed, reset beats WrAcc
        do_reset();
        sto(11'h020);
        ldi(11'h2AA);
        for (int i = 0; i < 5; i++) dbl(11'd6);
        alui(1'b0, 11'h015);
        check("sto_rst_setup", 32'(o_acc), 32'h5555);
        apply(1'b0, 11'h020, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_state("sto_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
        ld(11'h020);
        check("sto_rst_ram", 32'(o_acc), 32'h0000);

        // random against the model
        do_reset();
        for (int i = 0; i < 64; i++) sto(11'(i));
        for (int n = 0; n < 600; n++) begin
            r_rst     = ($urandom_range(0, 39) != 0);
            r_sela    = 2'($urandom_range(0, 3));
            r_selb    = 1'($urandom);
            r_wracc   = ($urandom_range(0, 3) != 0);
            r_op      = 1'($urandom);
            r_wrram   = ($urandom_range(0, 3) == 0);
            r_rdram   = 1'($urandom);
            r_operand = 11'($urandom_range(0, 2047));
            if (r_wrram || r_rdram) r_operand = 11'($urandom_range(0, 63));
            apply(r_rst, r_operand, r_sela, r_selb, r_wracc, r_op, r_wrram, r_rdram);
            exp_q.push_back({m_acc, m_z, m_c, m_o});
            exp_v = exp_q.pop_front();
            check($sformatf("rand[%0d]", n), {13'd0, o_acc, o_zero, o_carry, o_ovf}, {13'd0, exp_v});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
